// File: rtl/key_move_queue.sv
`default_nettype none
// ============================================================================
// Module   : key_move_queue
// Purpose  : Turns WASD / arrow key events from the keyboard decoder into
//            queued player-move commands, with hold-to-repeat auto-move and
//            a show-ahead valid/ready move FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module key_move_queue #(
    parameter int FIFO_DEPTH    = 4,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int CNT_W         = 25
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          key_valid,
    input  logic [8:0]                    last_change,
    input  logic [511:0]                  key_down,
    input  logic                          move_ready,
    output logic                          move_valid,
    output logic [1:0]                    move_dir,
    output logic                          move_drop,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    // Repeat state machine encoding
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_DELAY  = 2'd1;
    localparam logic [1:0] c_ST_REPEAT = 2'd2;

    // Direction codes as seen by the game logic
    localparam logic [1:0] c_DIR_UP    = 2'd0;
    localparam logic [1:0] c_DIR_DOWN  = 2'd1;
    localparam logic [1:0] c_DIR_LEFT  = 2'd2;
    localparam logic [1:0] c_DIR_RIGHT = 2'd3;

    // Repeat state
    logic [1:0]           r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [1:0]           r_rpt_dir;

    // Queue state
    logic [1:0]           r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_LVL_W-1:0]   r_level;
    logic                 r_drop;

    // Decode / control
    logic                 w_mapped;
    logic [1:0]           w_dir;
    logic                 w_key_held;
    logic                 w_press;
    logic                 w_release;
    logic                 w_fire;
    logic                 w_push;
    logic [1:0]           w_push_dir;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_wr_en;

    // Map scancodes (plain and extended) onto the four move directions
    always_comb begin
        w_mapped = 1'b1;
        w_dir    = c_DIR_UP;
        case (last_change)
            9'h01D, 9'h175: w_dir = c_DIR_UP;
            9'h01B, 9'h172: w_dir = c_DIR_DOWN;
            9'h01C, 9'h16B: w_dir = c_DIR_LEFT;
            9'h023, 9'h174: w_dir = c_DIR_RIGHT;
            default:        w_mapped = 1'b0;
        endcase
    end

    // The held-key bitmap already reflects this event, so its bit tells press from release
    assign w_key_held = key_down[last_change];
    assign w_press    = key_valid & w_mapped & w_key_held;
    assign w_release  = key_valid & w_mapped & ~w_key_held;

    // Auto-repeat expiry; a fresh press on the same cycle takes precedence
    assign w_fire = ((r_state == c_ST_DELAY)  && (r_cnt == CNT_W'(REPEAT_DELAY - 1))) ||
                    ((r_state == c_ST_REPEAT) && (r_cnt == CNT_W'(REPEAT_PERIOD - 1)));
    assign w_push     = w_press | w_fire;
    assign w_push_dir = w_press ? w_dir : r_rpt_dir;

    // A full queue still accepts a push when the head leaves on the same cycle
    assign w_full  = (r_level == c_LVL_W'(FIFO_DEPTH));
    assign w_pop   = (r_level != '0) & move_ready;
    assign w_wr_en = w_push & (~w_full | w_pop);

    // Hold-to-repeat timing: press restarts the delay, matching release stops it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_ST_IDLE;
            r_cnt     <= '0;
            r_rpt_dir <= c_DIR_UP;
        end else if (w_press) begin
            r_rpt_dir <= w_dir;
            r_state   <= c_ST_DELAY;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                c_ST_DELAY: begin
                    if (w_fire) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_REPEAT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                c_ST_REPEAT: begin
                    if (w_fire) r_cnt <= '0;
                    else        r_cnt <= r_cnt + CNT_W'(1);
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
            // Releasing a key other than the repeating one leaves the repeat running
            if (w_release && (w_dir == r_rpt_dir)) begin
                r_state <= c_ST_IDLE;
                r_cnt   <= '0;
            end
        end
    end

    // Show-ahead move FIFO with occupancy count and overflow pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= c_DIR_UP;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_drop   <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_mem[r_wr_ptr] <= w_push_dir;
                r_wr_ptr        <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            case ({w_wr_en, w_pop})
                2'b10:   r_level <= r_level + c_LVL_W'(1);
                2'b01:   r_level <= r_level - c_LVL_W'(1);
                default: r_level <= r_level;
            endcase
            r_drop <= w_push & w_full & ~w_pop;
        end
    end

    assign move_valid = (r_level != '0);
    assign move_dir   = r_mem[r_rd_ptr];
    assign move_drop  = r_drop;
    assign level      = r_level;

endmodule
`default_nettype wire

// File: tb/tb_key_move_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_key_move_queue
// Purpose  : Self-checking bench for key_move_queue; directed scenarios plus
//            randomized key traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_key_move_queue;

    localparam int DEPTH = 4;
    localparam int DLY   = 8;
    localparam int PER   = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic [8:0]   last_change;
    logic [511:0] key_down;
    logic         move_ready;
    logic         move_valid;
    logic [1:0]   move_dir;
    logic         move_drop;
    logic [2:0]   level;

    key_move_queue #(
        .FIFO_DEPTH    (DEPTH),
        .REPEAT_DELAY  (DLY),
        .REPEAT_PERIOD (PER),
        .CNT_W         (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_valid   (key_valid),
        .last_change (last_change),
        .key_down    (key_down),
        .move_ready  (move_ready),
        .move_valid  (move_valid),
        .move_dir    (move_dir),
        .move_drop   (move_drop),
        .level       (level)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of directions plus absolute time of the next repeat
    int     q[$];
    bit     active;
    int     rdir;
    longint next_fire;
    bit     exp_drop;
    longint cyc;

    // Mapped codes in pairs; direction = index / 2
    logic [8:0] codes [8] = '{9'h01D, 9'h175, 9'h01B, 9'h172, 9'h01C, 9'h16B, 9'h023, 9'h174};

    function automatic bit lookup(input logic [8:0] code, output int d);
        d = 0;
        for (int i = 0; i < 8; i++) begin
            if (codes[i] == code) begin
                d = i / 2;
                return 1'b1;
            end
        end
        return 1'b0;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Apply the current inputs to the model for the upcoming clock edge
    task automatic model_update();
        int  d;
        bit  mapped, press, rel, pop;
        int  pd, sz;
        if (rst) begin
            q.delete();
            active   = 1'b0;
            exp_drop = 1'b0;
            return;
        end
        mapped = lookup(last_change, d);
        press  = key_valid && mapped && key_down[last_change];
        rel    = key_valid && mapped && !key_down[last_change];
        pop    = (q.size() != 0) && move_ready;
        pd     = -1;
        if (press) begin
            pd        = d;
            active    = 1'b1;
            rdir      = d;
            next_fire = cyc + DLY;
        end else begin
            if (active && cyc == next_fire) begin
                pd        = rdir;
                next_fire = cyc + PER;
            end
            if (rel && d == rdir) active = 1'b0;
        end
        sz = q.size();
        if (pop) void'(q.pop_front());
        exp_drop = 1'b0;
        if (pd >= 0) begin
            if (sz < DEPTH || pop) q.push_back(pd);
            else                   exp_drop = 1'b1;
        end
    endtask

    task automatic compare_all();
        check_eq("valid", move_valid, (q.size() != 0) ? 1 : 0);
        check_eq("level", level, q.size());
        check_eq("drop", move_drop, exp_drop);
        if (q.size() != 0) check_eq("dir", move_dir, q[0]);
    endtask

    task automatic cycle_step();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        key_valid = 1'b0;
        compare_all();
    endtask

    task automatic press_key(input logic [8:0] code);
        key_down[code] = 1'b1;
        last_change    = code;
        key_valid      = 1'b1;
    endtask

    task automatic release_key(input logic [8:0] code);
        key_down[code] = 1'b0;
        last_change    = code;
        key_valid      = 1'b1;
    endtask

    task automatic do_reset();
        key_down  = '0;
        key_valid = 1'b0;
        rst       = 1'b1;
        cycle_step();
        rst       = 1'b0;
    endtask

    int exp4 [4] = '{1, 2, 0, 3};

    initial begin
        rst         = 1'b1;
        key_valid   = 1'b0;
        last_change = '0;
        key_down    = '0;
        move_ready  = 1'b0;
        cyc         = 0;
        active      = 1'b0;
        rdir        = 0;
        next_fire   = 0;
        exp_drop    = 1'b0;
        cycle_step();
        cycle_step();
        check_eq("rst_valid", move_valid, 0);
        check_eq("rst_level", level, 0);
        check_eq("rst_dir", move_dir, 0);
        check_eq("rst_drop", move_drop, 0);
        rst = 1'b0;

        // Single press with ready high, then release: exactly one move
        move_ready = 1'b1;
        press_key(9'h175);
        cycle_step();
        check_eq("s1_valid", move_valid, 1);
        check_eq("s1_dir", move_dir, 0);
        cycle_step();
        check_eq("s1_popped", move_valid, 0);
        release_key(9'h175);
        for (int k = 0; k < 12; k++) begin
            cycle_step();
            check_eq("s1_no_more", move_valid, 0);
        end

        // Hold right: pushes at 0, 8, 12; release at 14 suppresses 16
        do_reset();
        move_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 0)  press_key(9'h023);
            if (k == 14) release_key(9'h023);
            cycle_step();
            check_eq("s2_push", move_valid, (k == 0 || k == 8 || k == 12) ? 1 : 0);
        end

        // Overflow with ready low, then drain in order
        do_reset();
        move_ready = 1'b0;
        press_key(9'h01D); cycle_step();
        press_key(9'h01B); cycle_step();
        press_key(9'h01C); cycle_step();
        press_key(9'h023); cycle_step();
        check_eq("s3_full_level", level, 4);
        check_eq("s3_no_drop_yet", move_drop, 0);
        press_key(9'h175); cycle_step();
        check_eq("s3_drop", move_drop, 1);
        check_eq("s3_level", level, 4);
        move_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq("s3_order", move_dir, i);
            cycle_step();
        end
        check_eq("s3_empty", level, 0);

        // Full queue, push and pop together: no drop, new entry at tail
        do_reset();
        move_ready = 1'b0;
        press_key(9'h01D); cycle_step();
        press_key(9'h01B); cycle_step();
        press_key(9'h01C); cycle_step();
        press_key(9'h175); cycle_step();
        move_ready = 1'b1;
        press_key(9'h174); cycle_step();
        check_eq("s4_no_drop", move_drop, 0);
        check_eq("s4_level", level, 4);
        for (int i = 0; i < 4; i++) begin
            check_eq("s4_order", move_dir, exp4[i]);
            cycle_step();
        end

        // Hold W, press D at 5: repeats become right from 13; W release ignored
        do_reset();
        move_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            if (k == 0)  press_key(9'h01D);
            if (k == 5)  press_key(9'h023);
            if (k == 10) release_key(9'h01D);
            cycle_step();
            check_eq("s5_push", move_valid, (k == 0 || k == 5 || k == 13 || k == 17) ? 1 : 0);
            if (k == 13 || k == 17) check_eq("s5_dir", move_dir, 3);
        end

        // Unmapped code is ignored; reset during repeat cancels everything
        do_reset();
        move_ready = 1'b0;
        press_key(9'h029);
        for (int k = 0; k < 10; k++) begin
            cycle_step();
            check_eq("s6_unmapped", move_valid, 0);
        end
        press_key(9'h172);
        for (int k = 0; k < 11; k++) cycle_step();
        check_eq("s6_pre_rst", level, 2);
        rst = 1'b1;
        cycle_step();
        rst = 1'b0;
        check_eq("s6_rst_level", level, 0);
        check_eq("s6_rst_valid", move_valid, 0);
        for (int k = 0; k < 20; k++) begin
            cycle_step();
            check_eq("s6_after_rst", level, 0);
        end

        // Randomized key traffic
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            logic [8:0] code;
            rst        = ($urandom_range(0, 299) == 0);
            move_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 3) == 0) begin
                if ($urandom_range(0, 4) != 0) code = codes[$urandom_range(0, 7)];
                else                           code = 9'($urandom_range(0, 511));
                key_down[code] = ($urandom_range(0, 2) != 0);
                last_change    = code;
                key_valid      = 1'b1;
            end
            cycle_step();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
